// File: rtl/data_memory_ctrl.sv
// Handshaked single-port word RAM with byte strobes, one registered response per request.
// Define DMEM_CLEAR_ON_RESET_EN to zero the array with a sweep after every reset.
module data_memory_ctrl #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned ADDR_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err
);

  localparam int unsigned NB = DATA_W / 8;
  localparam int unsigned LB = $clog2(NB);
  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] LaneMask = ADDR_W'((64'd1 << LB) - 64'd1);

`ifdef DMEM_CLEAR_ON_RESET_EN
  localparam int unsigned CW = IW + 1;
  typedef enum logic [1:0] {StIdle, StResp, StClear} state_e;
  logic [CW-1:0] clr_cnt_q;
`else
  typedef enum logic [1:0] {StIdle, StResp} state_e;
`endif

  state_e              state_q;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [DATA_W-1:0]   rsp_rdata_q;
  logic                rsp_err_q;
  logic [ADDR_W-1:0]   idx_full;
  logic [IW-1:0]       widx;
  logic                req_err;
  logic                accept;

  always_comb begin
    idx_full = req_addr >> LB;
    widx     = idx_full[IW-1:0];
    req_err  = ((req_addr & LaneMask) != '0) || (idx_full >= ADDR_W'(DEPTH));
  end

  // rst gates ready so nothing is accepted in the reset cycle itself.
  assign req_ready = !rst && ((state_q == StIdle) || ((state_q == StResp) && rsp_ready));
  assign accept    = req_valid && req_ready;
  assign rsp_valid = (state_q == StResp);
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
`ifdef DMEM_CLEAR_ON_RESET_EN
      state_q   <= StClear;
      clr_cnt_q <= '0;
`else
      state_q   <= StIdle;
`endif
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      unique case (state_q)
`ifdef DMEM_CLEAR_ON_RESET_EN
        StClear: begin
          clr_cnt_q <= clr_cnt_q + CW'(1);
          if (clr_cnt_q == CW'(DEPTH - 1)) state_q <= StIdle;
        end
`endif
        StIdle:  if (accept) state_q <= StResp;
        StResp:  if (!accept && rsp_ready) state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
      if (accept) begin
        rsp_err_q   <= req_err;
        rsp_rdata_q <= (req_err || req_we) ? '0 : mem[widx];
      end
    end
  end

  // Array has no reset; writes commit at the accept edge.
  always_ff @(posedge clk) begin
`ifdef DMEM_CLEAR_ON_RESET_EN
    if (!rst && (state_q == StClear)) begin
      mem[clr_cnt_q[IW-1:0]] <= '0;
    end else
`endif
    if (accept && req_we && !req_err) begin
      for (int b = 0; b < NB; b++) begin
        if (req_be[b]) mem[widx][8*b +: 8] <= req_wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Self-checking bench for data_memory_ctrl: spec vectors, hand sequences and a random run
// checked against a transaction-level memory model.
module tb_data_memory_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_be = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int total = 0;
  int bad = 0;

  // Reference model: word array plus the single held response.
  logic [31:0] mem_m [64];
  logic        held = 1'b0;
  logic [31:0] held_rdata = '0;
  logic        held_err = 1'b0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        err;
    logic [31:0] rdata;
  } vec_t;
  vec_t tbl[15];

  data_memory_ctrl #(.DATA_W(32), .DEPTH(64), .ADDR_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model transaction: what the response to this request must be.
  task automatic model_req(input logic we, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] be);
    logic err;
    err = (a % 4 != 0) || ((a / 4) >= 64);
    held = 1'b1;
    held_err = err;
    held_rdata = '0;
    if (!err) begin
      if (we) begin
        for (int b = 0; b < 4; b++) if (be[b]) mem_m[a/4][8*b +: 8] = d[8*b +: 8];
      end else begin
        held_rdata = mem_m[a/4];
      end
    end
  endtask

  // One clock cycle: drive, check at negedge against model, advance model, return at posedge+1.
  task automatic tick(input logic v, input logic we, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] be, input logic rr);
    logic exp_ready;
    req_valid = v; req_we = we; req_addr = a; req_wdata = d; req_be = be; rsp_ready = rr;
    @(negedge clk);
    exp_ready = !held || rr;
    chk("req_ready", 32'(req_ready), 32'(exp_ready));
    chk("rsp_valid", 32'(rsp_valid), 32'(held));
    if (held) begin
      chk("rsp_rdata", rsp_rdata, held_rdata);
      chk("rsp_err", 32'(rsp_err), 32'(held_err));
    end
    if (held && rr) held = 1'b0;
    if (v && exp_ready) model_req(we, a, d, be);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    int cnt;
    rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    held = 1'b0;
`ifdef DMEM_CLEAR_ON_RESET_EN
    for (int i = 0; i < 64; i++) mem_m[i] = '0;
    cnt = 0;
    while (cnt < 200) begin
      @(negedge clk);
      if (req_ready) break;
      cnt++;
      @(posedge clk); #1;
    end
    chk("clear_len", 32'(cnt), 32'd64);
    if (cnt < 200) begin
      @(posedge clk); #1;
    end
`else
    cnt = 0;
    @(negedge clk);
    chk("ready_after_rst", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
`endif
  endtask

  task automatic chk_rsp(input string name, input logic err, input logic [31:0] rdata);
    chk({name, "_valid"}, 32'(rsp_valid), 32'd1);
    chk({name, "_err"}, 32'(rsp_err), 32'(err));
    chk({name, "_rdata"}, rsp_rdata, rdata);
  endtask

  initial begin
    logic [31:0] a;
    int r;
    tbl[0]  = '{1'b1, 32'h10,  32'hDEADBEEF, 4'hF, 1'b0, 32'h0};
    tbl[1]  = '{1'b0, 32'h10,  32'h0,        4'h0, 1'b0, 32'hDEADBEEF};
    tbl[2]  = '{1'b1, 32'h20,  32'h11223344, 4'hF, 1'b0, 32'h0};
    tbl[3]  = '{1'b1, 32'h20,  32'hAABBCCDD, 4'h5, 1'b0, 32'h0};
    tbl[4]  = '{1'b0, 32'h20,  32'h0,        4'hF, 1'b0, 32'h11BB33DD};
    tbl[5]  = '{1'b0, 32'h100, 32'h0,        4'h0, 1'b1, 32'h0};
    tbl[6]  = '{1'b1, 32'h0,   32'hCAFEF00D, 4'hF, 1'b0, 32'h0};
    tbl[7]  = '{1'b1, 32'h102, 32'h12345678, 4'hF, 1'b1, 32'h0};
    tbl[8]  = '{1'b0, 32'h0,   32'h0,        4'h0, 1'b0, 32'hCAFEF00D};
    tbl[9]  = '{1'b1, 32'h12,  32'h55555555, 4'hF, 1'b1, 32'h0};
    tbl[10] = '{1'b0, 32'h10,  32'h0,        4'h0, 1'b0, 32'hDEADBEEF};
    tbl[11] = '{1'b1, 32'h20,  32'hFFFFFFFF, 4'h0, 1'b0, 32'h0};
    tbl[12] = '{1'b0, 32'h20,  32'h0,        4'h0, 1'b0, 32'h11BB33DD};
    tbl[13] = '{1'b1, 32'hFC,  32'h0F0F0F0F, 4'hF, 1'b0, 32'h0};
    tbl[14] = '{1'b0, 32'hFC,  32'h0,        4'h0, 1'b0, 32'h0F0F0F0F};

    do_reset();

    // Fill the array so the model knows every word.
    for (int i = 0; i < 64; i++) tick(1'b1, 1'b1, 32'(i * 4), $urandom, 4'hF, 1'b1);
    tick(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1);

    for (int i = 0; i < 15; i++) begin
      tick(1'b1, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].be, 1'b1);
      chk_rsp($sformatf("vec%0d", i), tbl[i].err, tbl[i].rdata);
    end

    // Backpressure: held response must not move while rsp_ready is low.
    tick(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b0, 32'h20, 32'h0, 4'h0, 1'b0);
      chk_rsp("bp_hold", 1'b0, 32'hDEADBEEF);
    end
    tick(1'b1, 1'b0, 32'h20, 32'h0, 4'h0, 1'b1);
    chk_rsp("bp_next", 1'b0, 32'h11BB33DD);

    // Streaming writes then reads at full rate.
    for (int i = 0; i < 8; i++) begin
      tick(1'b1, 1'b1, 32'(i * 4), 32'(i) * 32'h01010101, 4'hF, 1'b1);
      chk_rsp("stream_wr", 1'b0, 32'h0);
    end
    for (int i = 0; i < 8; i++) begin
      tick(1'b1, 1'b0, 32'(i * 4), 32'h0, 4'h0, 1'b1);
      chk_rsp("stream_rd", 1'b0, 32'(i) * 32'h01010101);
    end

    // Reset while a response is held.
    tick(1'b1, 1'b0, 32'h4, 32'h0, 4'h0, 1'b0);
    tick(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    do_reset();
    tick(1'b1, 1'b0, 32'h4, 32'h0, 4'h0, 1'b1);
`ifdef DMEM_CLEAR_ON_RESET_EN
    chk_rsp("post_rst_rd", 1'b0, 32'h0);
`else
    chk_rsp("post_rst_rd", 1'b0, 32'h01010101);
`endif

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 9);
      if (r == 0) a = $urandom;
      else if (r == 1) a = {24'h0, 6'($urandom_range(0, 63)), 2'($urandom_range(1, 3))};
      else a = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
      tick(1'($urandom_range(0, 3) != 0), 1'($urandom), a, $urandom, 4'($urandom),
           1'($urandom_range(0, 9) < 7));
    end
    tick(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
    tick(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_memory_ctrl.md
# data_memory_ctrl

Parametrised, handshaked successor to the CPU data memory: a single-port synchronous word RAM with byte-lane write strobes, one registered response per request, and range/alignment error reporting. It sits between the load/store stage and the data RAM, and lets the pipeline stall on `req_ready` and `rsp_valid` instead of relying on combinational reads. An optional post-reset sweep zeroes the array before the first access.

## Interface
- `DATA_W`, 32: word width in bits; multiple of 8, at least 8.
- `DEPTH`, 64: number of words.
- `ADDR_W`, 32: byte-address width.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: request accepted when `req_valid && req_ready`.
- `req_we` in 1: 1 = write, 0 = read.
- `req_addr` in `ADDR_W`: byte address.
- `req_wdata` in `DATA_W`: write data.
- `req_be` in `DATA_W/8`: byte-lane write enables; ignored on reads.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: response consumed when `rsp_valid && rsp_ready`.
- `rsp_rdata` out `DATA_W`: read data; 0 for writes and for errored requests.
- `rsp_err` out 1: request was out of range or misaligned.

## Operation
- `LB = log2(DATA_W/8)`; word index `idx = req_addr >> LB`.
- Misaligned: `req_addr[LB-1:0] != 0`. Out of range: `idx >= DEPTH`. Either condition makes the request errored.
- An errored request performs no array access. Its response carries `rsp_err=1` and `rsp_rdata=0`.
- Write: for each lane `b` with `req_be[b]=1`, `mem[idx][8b+7:8b] <= req_wdata[8b+7:8b]`. Other lanes keep their value. `req_be=0` is a legal no-op write and still gets a response.
- Read: the word at `mem[idx]` is captured into the response register.
- Every accepted request produces exactly one response, in order. At most one response is held at a time.
- States:
  - CLEAR: only with the macro.
  - IDLE: no response held.
  - RESP: response held.
- Transitions:
  - IDLE→RESP on accept.
  - RESP→RESP on accept with `rsp_ready=1` (back-to-back).
  - RESP→IDLE on `rsp_ready=1` with no accept.
  - RESP holds when `rsp_ready=0`.
- `req_ready = (state==IDLE) || (state==RESP && rsp_ready)`.
- While `rsp_valid=1 && rsp_ready=0`, `rsp_rdata` and `rsp_err` are stable.

## Timing
- Reset values: `req_ready=0` for the cycle `rst` is high, `rsp_valid=0`, `rsp_rdata=0`, `rsp_err=0`. State after reset is IDLE, or CLEAR with the macro.
- Latency: a request accepted at edge N gives `rsp_valid=1` after edge N; the response is visible in cycle N+1.
- Throughput: 1 request/cycle while `rsp_ready` stays high.
- Read after write to the same word on consecutive accepts returns the newly written data, because the array write commits at the accept edge.
- `rst` asserted mid-operation drops any held response without handing it over. Array contents are unchanged without the macro. With the macro the sweep restarts from word 0.
- The array has no reset. Contents are undefined at power-up unless the sweep runs.

## Configuration
- `DMEM_CLEAR_ON_RESET_EN` defined:
  - After `rst` deasserts, the block enters CLEAR and writes 0 to word `k` each cycle, `k = 0..DEPTH-1`.
  - `req_ready=0` throughout CLEAR. The block enters IDLE after writing word `DEPTH-1`, so `req_ready` first rises `DEPTH` cycles after `rst` falls.
  - The sweep counter is `log2(DEPTH)+1` bits wide.
- Not defined:
  - No CLEAR state and no sweep counter.
  - `req_ready=1` in the first cycle after `rst` falls.

## Test plan
- Full-word write then read: write `addr=0x10`, `wdata=0xDEADBEEF`, `be=4'hF`, then read `0x10` → read response `rdata=0xDEADBEEF`, `err=0`, valid one cycle after accept.
- Byte strobes: word `0x20` holds `0x11223344`; write `wdata=0xAABBCCDD`, `be=4'b0101`; then read `0x20` → `0x11BB33DD`.
- Backpressure: read accepted with `rsp_ready=0` for 3 cycles → `rsp_valid` and `rsp_rdata` held constant, `req_ready=0`. With `rsp_ready=1`, a new read is accepted in the same cycle and its data appears the next cycle.
- Errors (`DEPTH=64`):
  - read `0x100` → `err=1`, `rdata=0`.
  - write `0x102` → `err=1`, memory unchanged (checked by a later read).
- Streaming: 8 back-to-back writes to `0x0..0x1C` with data `i*0x01010101`, then 8 back-to-back reads with `rsp_ready` held at 1 → 16 responses in order with matching data, no idle cycles.
- Reset:
  - With `DMEM_CLEAR_ON_RESET_EN`: `req_ready` rises exactly 64 cycles after `rst` falls, and a read of any word returns 0.
  - Without the macro: `rst` pulsed while a response is held → `rsp_valid=0`, and previously written data survives.
